// File: rtl/davio_sweep_ctrl.sv
// davio_sweep_ctrl
// Self-check sequencer for the 7-input Davio-decomposed parity evaluator.
// On an accepted start it sweeps the inclusive range lo..hi (wrap-around
// allowed) onto the shared evaluator input bus. For every vector it compares
// the evaluator output against the golden model, after a PIPE_LAT-deep
// alignment delay. It reports a saturating mismatch count, the first failing
// vector and pass/fail through a start/busy/done handshake.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      sweep request (IDLE only) / abandon the sweep in progress
//   lo, hi            inclusive sweep range, latched on an accepted start
//   vec_out/vec_valid vector driven to the evaluator D inputs / qualifier
//   f_dut, f_ref      evaluator F and golden-model F_conventional
//   busy, done        high in RUN/DRAIN/DONE; one-cycle completion pulse
//   pass              no mismatches in the completed sweep
//   err_count         saturating mismatch count
//   first_fail(_valid) first mismatching vector and its qualifier
//
// Parameters
//   WIDTH     evaluator input width
//   PIPE_LAT  evaluator latency in cycles, 0..4 (0 = combinational evaluator)
//   ERR_W     mismatch counter width

module davio_sweep_ctrl #(
  parameter int WIDTH    = 7,
  parameter int PIPE_LAT = 0,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_valid,
  input  logic             f_dut,
  input  logic             f_ref,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_fail,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // DRAIN counts down from PIPE_LAT-1 to 0, giving exactly PIPE_LAT cycles.
  localparam logic [2:0] DRAIN_INIT = 3'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_vec;
  logic             r_vec_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [WIDTH-1:0] r_ff;
  logic             r_ffv;
  logic [2:0]       r_drain_cnt;

  logic             w_flush;
  logic             w_cmp_vld;
  logic [WIDTH-1:0] w_cmp_vec;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_last;

  assign w_flush = abort && (r_state != S_IDLE);

  // Alignment: delay the issued vector by the evaluator latency so the
  // compare sees the vector that produced the current f_dut/f_ref.
  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign w_cmp_vld = r_vec_valid;
      assign w_cmp_vec = r_vec;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0]            r_vld_pipe;
      logic [PIPE_LAT-1:0][WIDTH-1:0] r_vec_pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_pipe <= '0;
          r_vec_pipe <= '0;
        end else if (w_flush) begin
          r_vld_pipe <= '0;
          r_vec_pipe <= '0;
        end else begin
          r_vld_pipe[0] <= r_vec_valid;
          r_vec_pipe[0] <= r_vec;
          for (int i = 1; i < PIPE_LAT; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_vec_pipe[i] <= r_vec_pipe[i-1];
          end
        end
      end

      assign w_cmp_vld = r_vld_pipe[PIPE_LAT-1];
      assign w_cmp_vec = r_vec_pipe[PIPE_LAT-1];
    end
  endgenerate

  assign w_mismatch = w_cmp_vld && (f_dut != f_ref);
  // Saturating increment: holds at all-ones.
  assign w_err_nxt  = (w_mismatch && (r_err != {ERR_W{1'b1}})) ? r_err + 1'b1 : r_err;
  assign w_last     = (r_vec == r_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hi        <= '0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_ff        <= '0;
      r_ffv       <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_done <= 1'b0;

      // Compare bookkeeping runs in any state; the alignment pipe is empty in
      // IDLE, so nothing is counted there.
      if (w_mismatch) begin
        r_err <= w_err_nxt;
        if (!r_ffv) begin
          r_ff  <= w_cmp_vec;
          r_ffv <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hi        <= hi;
            r_vec       <= lo;
            r_vec_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_err       <= '0;
            r_ff        <= '0;
            r_ffv       <= 1'b0;
            r_pass      <= 1'b0;
            r_state     <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
          end else if (w_last) begin
            // vec_out holds hi; only the qualifier drops.
            r_vec_valid <= 1'b0;
            if (PIPE_LAT > 0) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= DRAIN_INIT;
            end else begin
              // The last vector is compared this cycle, so pass uses the
              // post-compare count.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == '0);
            end
          end else begin
            r_vec <= r_vec + 1'b1;
          end
        end

        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_drain_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (abort) r_pass <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_out          = r_vec;
  assign vec_valid        = r_vec_valid;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail       = r_ff;
  assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_davio_sweep_ctrl.sv
// Bench for davio_sweep_ctrl: two instances share the control inputs,
// A with a combinational evaluator (PIPE_LAT=0, ERR_W=8) and B with a
// two-stage evaluator (PIPE_LAT=2, ERR_W=4). Each evaluator stub computes
// parity of its D input and inverts f_dut wherever fmask marks the vector.
module tb_davio_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] lo = '0;
  logic [6:0] hi = '0;

  logic [6:0] a_vec, a_ff;
  logic       a_valid, a_fdut, a_fref, a_busy, a_done, a_pass, a_ffv;
  logic [7:0] a_err;
  logic [6:0] b_vec, b_ff;
  logic       b_valid, b_fdut, b_fref, b_busy, b_done, b_pass, b_ffv;
  logic [3:0] b_err;

  logic [127:0] fmask = '0;
  logic [6:0]   b_d1 = '0, b_d2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a_fref = ^a_vec;
  assign a_fdut = a_fref ^ fmask[a_vec];
  always @(posedge clk) begin
    b_d1 <= b_vec;
    b_d2 <= b_d1;
  end
  assign b_fref = ^b_d2;
  assign b_fdut = b_fref ^ fmask[b_d2];

  davio_sweep_ctrl #(.WIDTH(7), .PIPE_LAT(0), .ERR_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .vec_out(a_vec), .vec_valid(a_valid), .f_dut(a_fdut), .f_ref(a_fref),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail(a_ff), .first_fail_valid(a_ffv));

  davio_sweep_ctrl #(.WIDTH(7), .PIPE_LAT(2), .ERR_W(4)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .vec_out(b_vec), .vec_valid(b_valid), .f_dut(b_fdut), .f_ref(b_fref),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail(b_ff), .first_fail_valid(b_ffv));

  typedef struct {
    logic [6:0] lo, hi;
    int         mode;        // 0 clean, 1 faults at 0x15/0x40, 2 all, 3 random
    int         restart_at;  // cycle to pulse start mid-sweep (0 = never)
    int         abort_at;    // cycle to pulse abort (0 = never)
    int         exp_nvec;
    int         exp_err_a, exp_err_b;
    logic [6:0] exp_ff;
    bit         exp_ffv, exp_pass, exp_done;
  } row_t;

  row_t rows[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: outcome of a sweep from the range and the fault mask alone.
  task automatic model(input logic [127:0] m, inout row_t r);
    int n, cnt;
    bit got;
    cnt = 0; got = 0;
    n = ((int'(r.hi) - int'(r.lo) + 128) % 128) + 1;
    r.exp_nvec = n;
    r.exp_ff   = '0;
    for (int i = 0; i < n; i++) begin
      int v;
      v = (int'(r.lo) + i) % 128;
      if (m[v]) begin
        if (!got) begin r.exp_ff = 7'(v); got = 1; end
        cnt++;
      end
    end
    r.exp_ffv   = got;
    r.exp_err_a = (cnt > 255) ? 255 : cnt;
    r.exp_err_b = (cnt > 15) ? 15 : cnt;
    r.exp_pass  = (cnt == 0);
    r.exp_done  = 1;
  endtask

  task automatic run_row(input row_t r, input int idx);
    int n_a = 0, n_b = 0, bad_a = 0, bad_b = 0;
    int fv_a = -1, fv_b = -1, dc_a = -1, dc_b = -1, dn_a = 0, dn_b = 0;
    int bz_a = 0, bz_b = 0, limit;
    limit = r.exp_nvec + 8;
    @(negedge clk);
    lo = r.lo; hi = r.hi; start = 1'b1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (a_valid) begin
        if (a_vec !== 7'((int'(r.lo) + n_a) % 128)) bad_a++;
        if (fv_a < 0) fv_a = cyc;
        n_a++;
      end
      if (b_valid) begin
        if (b_vec !== 7'((int'(r.lo) + n_b) % 128)) bad_b++;
        if (fv_b < 0) fv_b = cyc;
        n_b++;
      end
      if (a_done) begin dn_a++; dc_a = cyc; bz_a = a_busy; end
      if (b_done) begin dn_b++; dc_b = cyc; bz_b = b_busy; end
      if (r.abort_at > 0 && cyc == r.abort_at + 1) begin
        chk($sformatf("r%0d A.busy_after_abort", idx), a_busy, 0);
        chk($sformatf("r%0d B.busy_after_abort", idx), b_busy, 0);
      end
      start = (cyc == r.restart_at);
      abort = (cyc == r.abort_at);
      if (cyc == r.restart_at) begin lo = 7'h05; hi = 7'h06; end
      else begin lo = r.lo; hi = r.hi; end
    end
    chk($sformatf("r%0d A.nvec", idx), n_a, r.exp_nvec);
    chk($sformatf("r%0d B.nvec", idx), n_b, r.exp_nvec);
    chk($sformatf("r%0d A.vecseq_bad", idx), bad_a, 0);
    chk($sformatf("r%0d B.vecseq_bad", idx), bad_b, 0);
    chk($sformatf("r%0d A.first_valid_cyc", idx), fv_a, 1);
    chk($sformatf("r%0d B.first_valid_cyc", idx), fv_b, 1);
    chk($sformatf("r%0d A.done_cnt", idx), dn_a, r.exp_done ? 1 : 0);
    chk($sformatf("r%0d B.done_cnt", idx), dn_b, r.exp_done ? 1 : 0);
    if (r.exp_done) begin
      chk($sformatf("r%0d A.done_cyc", idx), dc_a, r.exp_nvec + 1);
      chk($sformatf("r%0d B.done_cyc", idx), dc_b, r.exp_nvec + 3);
      chk($sformatf("r%0d A.busy_in_done", idx), bz_a, 1);
      chk($sformatf("r%0d B.busy_in_done", idx), bz_b, 1);
    end
    chk($sformatf("r%0d A.err", idx), a_err, r.exp_err_a);
    chk($sformatf("r%0d B.err", idx), b_err, r.exp_err_b);
    chk($sformatf("r%0d A.ffv", idx), a_ffv, r.exp_ffv);
    chk($sformatf("r%0d B.ffv", idx), b_ffv, r.exp_ffv);
    chk($sformatf("r%0d A.ff", idx), a_ff, r.exp_ff);
    chk($sformatf("r%0d B.ff", idx), b_ff, r.exp_ff);
    chk($sformatf("r%0d A.pass", idx), a_pass, r.exp_pass);
    chk($sformatf("r%0d B.pass", idx), b_pass, r.exp_pass);
    chk($sformatf("r%0d A.idle", idx), {a_busy, a_valid}, 0);
    chk($sformatf("r%0d B.idle", idx), {b_busy, b_valid}, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " A.outs"}, {a_vec, a_valid, a_busy, a_done, a_pass, a_err, a_ff, a_ffv}, 0);
    chk({tag, " B.outs"}, {b_vec, b_valid, b_busy, b_done, b_pass, b_err, b_ff, b_ffv}, 0);
  endtask

  function automatic row_t mk(input logic [6:0] l, input logic [6:0] h, input int mode,
                              input int rs, input int ab, input int nv, input int ea,
                              input int eb, input logic [6:0] ff, input bit ffv,
                              input bit ps, input bit dn);
    row_t r;
    r.lo = l; r.hi = h; r.mode = mode; r.restart_at = rs; r.abort_at = ab;
    r.exp_nvec = nv; r.exp_err_a = ea; r.exp_err_b = eb; r.exp_ff = ff;
    r.exp_ffv = ffv; r.exp_pass = ps; r.exp_done = dn;
    return r;
  endfunction

  initial begin
    //            lo     hi     md rs  ab  nvec eA   eB  ff     ffv ps dn
    rows[0] = mk(7'h00, 7'h7F, 0, 0,  0,  128, 0,   0,  7'h00, 0,  1, 1);
    rows[1] = mk(7'h00, 7'h7F, 1, 0,  0,  128, 2,   2,  7'h15, 1,  0, 1);
    rows[2] = mk(7'h7E, 7'h01, 0, 0,  0,  4,   0,   0,  7'h00, 0,  1, 1);
    rows[3] = mk(7'h33, 7'h33, 0, 0,  0,  1,   0,   0,  7'h00, 0,  1, 1);
    rows[4] = mk(7'h10, 7'h0F, 2, 0,  0,  128, 128, 15, 7'h10, 1,  0, 1);
    rows[5] = mk(7'h00, 7'h3F, 0, 10, 0,  64,  0,   0,  7'h00, 0,  1, 1);
    rows[6] = mk(7'h00, 7'h7F, 1, 0,  51, 51,  1,   1,  7'h15, 1,  0, 0);
    rows[7] = mk(7'h33, 7'h33, 2, 0,  0,  1,   1,   1,  7'h33, 1,  0, 1);
    for (int i = 8; i < 14; i++)
      rows[i] = mk(7'($urandom), 7'($urandom), 3, 0, 0, 0, 0, 0, 7'h00, 0, 0, 1);

    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("post_reset_idle");

    for (int i = 0; i < 14; i++) begin
      case (rows[i].mode)
        0: fmask = '0;
        1: begin fmask = '0; fmask[7'h15] = 1'b1; fmask[7'h40] = 1'b1; end
        2: fmask = '1;
        default: begin
          case ($urandom_range(0, 2))
            0: fmask = '0;
            1: fmask = {$urandom, $urandom, $urandom, $urandom}
                     & {$urandom, $urandom, $urandom, $urandom}
                     & {$urandom, $urandom, $urandom, $urandom};
            default: fmask = {$urandom, $urandom, $urandom, $urandom};
          endcase
          model(fmask, rows[i]);
        end
      endcase
      run_row(rows[i], i);
    end

    // Results hold in IDLE; abort there has no effect.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold A", {a_err, a_ff, a_ffv, a_pass},
        {8'(rows[13].exp_err_a), rows[13].exp_ff, rows[13].exp_ffv, rows[13].exp_pass});
    chk("idle_hold B", {b_err, b_ff, b_ffv, b_pass},
        {4'(rows[13].exp_err_b), rows[13].exp_ff, rows[13].exp_ffv, rows[13].exp_pass});
    chk("idle_hold busy", {a_busy, b_busy, a_done, b_done}, 0);

    // Reset mid-sweep at vector 20 (issued in cycle 21), between clock edges.
    fmask = '1;
    @(negedge clk); lo = 7'h00; hi = 7'h7F; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst A.vec", a_vec, 7'd20);
    chk("pre_rst B.err", b_err, 4'd15);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(negedge clk); rst = 1'b0;
    begin
      int dn;
      dn = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (a_done || b_done || a_busy || b_busy) dn++;
      end
      chk("post_rst quiet", dn, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/davio_sweep_ctrl.md
Name: davio_sweep_ctrl

Overview:
- Self-check sequencer for the 7-input Davio-decomposed parity evaluator and its conventional golden model.
- On start, it sweeps an inclusive input range (wrap-around allowed) onto the shared evaluator input bus.
- It compares F against F_conventional for every vector, with an optional evaluator pipeline depth.
- It reports the mismatch count, the first failing vector and pass/fail, using a start/busy/done handshake.

Parameters:
- WIDTH, 7, width of the evaluator input vector D.
- PIPE_LAT, 0, clock cycles from vec_out to the matching F/F_conventional (0 = purely combinational evaluator); legal values 0..4.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request; sampled only in IDLE.
- abort  input  1  abandon the sweep in progress.
- lo  input  WIDTH  first vector of the range; sampled on an accepted start.
- hi  input  WIDTH  last vector of the range, inclusive; sampled on an accepted start.
- vec_out  output  WIDTH  vector driven to the evaluator D inputs.
- vec_valid  output  1  vec_out carries a sweep vector this cycle.
- f_dut  input  1  F from the Davio evaluator.
- f_ref  input  1  F_conventional from the golden model.
- busy  output  1  high in RUN, DRAIN and DONE.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  err_count==0 at completion; valid from DONE until the next start.
- err_count  output  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- first_fail  output  WIDTH  first mismatching vector.
- first_fail_valid  output  1  first_fail holds a captured vector.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - vec_out=0, vec_valid=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0.
  - The alignment shift register is cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches lo/hi and clears err_count, first_fail, first_fail_valid and pass.
  - The next state is RUN with vec_out=lo.
  - Results from the previous sweep stay stable in IDLE until an accepted start.
- RUN:
  - vec_valid=1 for the whole state.
  - vec_out advances by 1 per cycle, modulo 2^WIDTH; after 2^WIDTH-1 it wraps to 0.
  - The cycle that issues hi is the last RUN cycle.
  - Vector count = ((hi-lo) mod 2^WIDTH)+1. lo==hi sweeps exactly one vector; lo=hi+1 (mod 2^WIDTH) sweeps all 2^WIDTH vectors.
  - After the last RUN cycle: go to DRAIN if PIPE_LAT>0, otherwise straight to DONE.
  - vec_out holds its last value after RUN; vec_valid=0 outside RUN.
- Alignment:
  - vec_valid and vec_out are delayed by a PIPE_LAT-deep shift register.
  - The compare is performed in the cycle the delayed valid is high, using the delayed vector.
  - Compare against f_dut/f_ref sampled in that same cycle.
- Compare:
  - A mismatch is f_dut != f_ref.
  - On a mismatch, err_count increments, saturating: it holds at 2^ERR_W-1.
  - If first_fail_valid==0, first_fail is loaded with the delayed vector and first_fail_valid is set.
  - Later mismatches never overwrite first_fail.
- DRAIN: lasts exactly PIPE_LAT cycles; compares continue for in-flight vectors.
- DONE:
  - Lasts 1 cycle with done=1; pass=(err_count==0), including the final compare.
  - The next state is IDLE.
- Latency: start accepted at cycle 0 → vector k-th issued at cycle k+1 → its compare at cycle k+1+PIPE_LAT → done at cycle N+1+PIPE_LAT, where N is the vector count.
- start while busy is ignored; it is not queued.
- abort=1 in RUN/DRAIN/DONE:
  - Next state is IDLE, the pipeline is flushed, done is not pulsed and pass=0.
  - err_count and first_fail keep their partial values.
- abort has priority over start. abort in IDLE has no effect.
- rst asserted mid-sweep behaves as full reset; no done pulse.

Test Plan:
- Full sweep, PIPE_LAT=0, f_dut tied to f_ref, lo=0, hi=127:
  - vec_out runs 0..127 on cycles 1..128.
  - done pulses at cycle 129 with pass=1, err_count=0 and first_fail_valid=0.
- Fault injection, PIPE_LAT=2, stub inverting f_dut for vectors 0x15 and 0x40:
  - err_count=2, first_fail=0x15, pass=0.
  - done pulses at cycle 131.
- Wrap range, lo=0x7E, hi=0x01:
  - vec_out = 0x7E, 0x7F, 0x00, 0x01.
  - done pulses at cycle 5+PIPE_LAT.
- Single vector lo=hi=0x33 and full-range lo=0x10, hi=0x0F:
  - The single-vector case yields 1 vector.
  - The full-range case yields 128 vectors, counted via vec_valid.
- Saturation, ERR_W=4, f_dut=~f_ref across 128 vectors:
  - err_count=15 and first_fail=lo.
- Control edge cases:
  - start pulsed mid-RUN: no restart.
  - abort at vector 50: busy drops next cycle, no done pulse.
  - rst at vector 20: all outputs at their reset values asynchronously.
